// File: rtl/bram_port_scheduler.sv
// Shares one single-port BRAM between the DSP datapath (priority) and the host bridge.
// Read data returns through a latency-matched tag pipeline; host responses are held until consumed.
module bram_port_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int STARVE_MAX = 8,
  parameter int BRAM_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dsp_addr,
  input  logic [DATA_WIDTH-1:0] dsp_din,
  input  logic                  dsp_we,
  input  logic                  dsp_valid,
  output logic                  dsp_ready,
  output logic [DATA_WIDTH-1:0] dsp_dout,
  output logic                  dsp_dout_valid,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_din,
  input  logic                  host_we,
  input  logic                  host_valid,
  output logic                  host_ready,
  output logic [DATA_WIDTH-1:0] host_dout,
  output logic                  host_dout_valid,
  input  logic                  host_dout_ready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_en,
  output logic                  bram_we,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  localparam logic [7:0] STARVE_LIMIT = 8'(STARVE_MAX);

  logic                  grant_dsp;
  logic                  grant_host;
  logic                  host_rd_busy;
  logic                  host_eligible;
  logic                  tag_exit_dsp;
  logic                  tag_exit_host;
  logic [7:0]            starve_cnt;
  logic [BRAM_LAT-1:0]   tag_valid;
  logic [BRAM_LAT-1:0]   tag_host;
  logic [DATA_WIDTH-1:0] dsp_dout_q;

  // A host read stays "busy" from acceptance until its held response is consumed.
  assign host_rd_busy  = (|(tag_valid & tag_host)) | host_dout_valid;
  assign host_eligible = host_valid & (host_we | ~host_rd_busy);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    grant_dsp  = 1'b0;
    grant_host = 1'b0;
    // rst is active-low: grants are only issued while out of reset.
    if (rst) begin
      if ((starve_cnt == STARVE_LIMIT) && host_eligible) grant_host = 1'b1;
      else if (dsp_valid)                                 grant_dsp  = 1'b1;
      else if (host_eligible)                             grant_host = 1'b1;
    end
  end

  assign dsp_ready  = grant_dsp;
  assign host_ready = grant_host;
  assign bram_en    = grant_dsp | grant_host;
  assign bram_we    = grant_host ? host_we : (grant_dsp & dsp_we);
  assign bram_addr  = grant_host ? host_addr : dsp_addr;
  assign bram_din   = grant_host ? host_din  : dsp_din;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_host || !host_eligible) begin
      starve_cnt <= '0;
    end else if (grant_dsp && (starve_cnt != STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Tag shift register mirrors the BRAM read latency; the last stage lines up with bram_dout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid <= '0;
      tag_host  <= '0;
    end else begin
      tag_valid[0] <= (grant_dsp & ~dsp_we) | (grant_host & ~host_we);
      tag_host[0]  <= grant_host & ~host_we;
      for (int i = 1; i < BRAM_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_host[i]  <= tag_host[i-1];
      end
    end
  end

  assign tag_exit_dsp  = tag_valid[BRAM_LAT-1] & ~tag_host[BRAM_LAT-1];
  assign tag_exit_host = tag_valid[BRAM_LAT-1] &  tag_host[BRAM_LAT-1];

  // DSP data is forwarded in the exit cycle and held in a register afterwards.
  assign dsp_dout_valid = tag_exit_dsp;
  assign dsp_dout       = tag_exit_dsp ? bram_dout : dsp_dout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dsp_dout_q <= '0;
    end else if (tag_exit_dsp) begin
      dsp_dout_q <= bram_dout;
    end
  end

  // Only one host read is ever outstanding, so capture and consume never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      host_dout       <= '0;
      host_dout_valid <= 1'b0;
    end else if (tag_exit_host) begin
      host_dout       <= bram_dout;
      host_dout_valid <= 1'b1;
    end else if (host_dout_valid && host_dout_ready) begin
      host_dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bram_port_scheduler.sv
// Drives two schedulers (BRAM_LAT=1/STARVE_MAX=8 and BRAM_LAT=3/STARVE_MAX=3) against a
// transaction-level reference: request queues, an outstanding-read list with due cycles, shadow memory.
module tb_bram_port_scheduler;

  localparam int DW = 32;
  localparam int AW = 10;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } req_t;

  typedef struct {
    int            due;
    bit            is_host;
    logic [DW-1:0] data;
  } rd_t;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int sm_of(input int i);
    return (i == 0) ? 8 : 3;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [AW-1:0] dsp_addr [2];
  logic [DW-1:0] dsp_din [2];
  logic          dsp_we [2];
  logic          dsp_valid [2];
  logic          dsp_ready [2];
  logic [DW-1:0] dsp_dout [2];
  logic          dsp_dout_valid [2];
  logic [AW-1:0] host_addr [2];
  logic [DW-1:0] host_din [2];
  logic          host_we [2];
  logic          host_valid [2];
  logic          host_ready [2];
  logic [DW-1:0] host_dout [2];
  logic          host_dout_valid [2];
  logic          host_dout_ready [2];
  logic [AW-1:0] bram_addr [2];
  logic [DW-1:0] bram_din [2];
  logic          bram_en [2];
  logic          bram_we [2];
  logic [DW-1:0] bram_dout [2];

  always #5 clk = ~clk;

  bram_port_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_MAX(8), .BRAM_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .dsp_addr(dsp_addr[0]), .dsp_din(dsp_din[0]), .dsp_we(dsp_we[0]), .dsp_valid(dsp_valid[0]),
    .dsp_ready(dsp_ready[0]), .dsp_dout(dsp_dout[0]), .dsp_dout_valid(dsp_dout_valid[0]),
    .host_addr(host_addr[0]), .host_din(host_din[0]), .host_we(host_we[0]), .host_valid(host_valid[0]),
    .host_ready(host_ready[0]), .host_dout(host_dout[0]), .host_dout_valid(host_dout_valid[0]),
    .host_dout_ready(host_dout_ready[0]),
    .bram_addr(bram_addr[0]), .bram_din(bram_din[0]), .bram_en(bram_en[0]), .bram_we(bram_we[0]),
    .bram_dout(bram_dout[0])
  );

  bram_port_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_MAX(3), .BRAM_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .dsp_addr(dsp_addr[1]), .dsp_din(dsp_din[1]), .dsp_we(dsp_we[1]), .dsp_valid(dsp_valid[1]),
    .dsp_ready(dsp_ready[1]), .dsp_dout(dsp_dout[1]), .dsp_dout_valid(dsp_dout_valid[1]),
    .host_addr(host_addr[1]), .host_din(host_din[1]), .host_we(host_we[1]), .host_valid(host_valid[1]),
    .host_ready(host_ready[1]), .host_dout(host_dout[1]), .host_dout_valid(host_dout_valid[1]),
    .host_dout_ready(host_dout_ready[1]),
    .bram_addr(bram_addr[1]), .bram_din(bram_din[1]), .bram_en(bram_en[1]), .bram_we(bram_we[1]),
    .bram_dout(bram_dout[1])
  );

  // Behavioural BRAMs with 1- and 3-cycle read latency; idle cycles return noise.
  bit   [DW-1:0] mem [2][1 << AW];
  logic [DW-1:0] pipe [2][3];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      pipe[i][2] <= pipe[i][1];
      pipe[i][1] <= pipe[i][0];
      pipe[i][0] <= (bram_en[i] && !bram_we[i]) ? mem[i][bram_addr[i]] : DW'($urandom);
      if (bram_en[i] && bram_we[i]) mem[i][bram_addr[i]] <= bram_din[i];
    end
  end

  assign bram_dout[0] = pipe[0][0];
  assign bram_dout[1] = pipe[1][2];

  // Reference state.
  req_t          dsp_q [2][$];
  req_t          host_q [2][$];
  rd_t           rd_q [2][$];
  bit   [DW-1:0] shadow [2][1 << AW];
  int            starve [2];
  bit            resp_v [2];
  logic [DW-1:0] resp_d [2];
  int            cyc;

  // Observations used by directed checks.
  int            obs_run [2];
  int            first_run [2];
  int            host_grants [2];
  logic [DW-1:0] last_dsp_data [2];
  logic [DW-1:0] last_host_data [2];

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input int inst, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s[%0d]: observed 0x%0h expected 0x%0h", tag, inst, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (dsp_q[i].size() > 0) begin
        dsp_valid[i] = 1'b1;
        dsp_we[i]    = dsp_q[i][0].we;
        dsp_addr[i]  = dsp_q[i][0].addr;
        dsp_din[i]   = dsp_q[i][0].din;
      end else begin
        dsp_valid[i] = 1'b0;
        dsp_we[i]    = 1'($urandom);
        dsp_addr[i]  = AW'($urandom);
        dsp_din[i]   = $urandom;
      end
      if (host_q[i].size() > 0) begin
        host_valid[i] = 1'b1;
        host_we[i]    = host_q[i][0].we;
        host_addr[i]  = host_q[i][0].addr;
        host_din[i]   = host_q[i][0].din;
      end else begin
        host_valid[i] = 1'b0;
        host_we[i]    = 1'($urandom);
        host_addr[i]  = AW'($urandom);
        host_din[i]   = $urandom;
      end
    end
  endtask

  task automatic model_cycle(input int i);
    bit   busy, elig, g_dsp, g_host, ex;
    req_t r;
    if (!rst) begin
      check("rst_dsp_ready", i, dsp_ready[i], 0);
      check("rst_host_ready", i, host_ready[i], 0);
      check("rst_bram_en", i, bram_en[i], 0);
      check("rst_bram_we", i, bram_we[i], 0);
      check("rst_dsp_dout_valid", i, dsp_dout_valid[i], 0);
      check("rst_host_dout_valid", i, host_dout_valid[i], 0);
      check("rst_host_dout", i, host_dout[i], 0);
      rd_q[i].delete();
      resp_v[i] = 1'b0;
      resp_d[i] = '0;
      starve[i] = 0;
      return;
    end
    busy = resp_v[i];
    for (int k = 0; k < rd_q[i].size(); k++) if (rd_q[i][k].is_host) busy = 1'b1;
    elig   = host_valid[i] && (host_we[i] || !busy);
    g_host = elig && ((starve[i] == sm_of(i)) || !dsp_valid[i]);
    g_dsp  = dsp_valid[i] && !g_host;
    ex     = (rd_q[i].size() > 0) && (rd_q[i][0].due == cyc);

    check("dsp_ready", i, dsp_ready[i], g_dsp);
    check("host_ready", i, host_ready[i], g_host);
    check("bram_en", i, bram_en[i], g_dsp || g_host);
    if (g_dsp || g_host) begin
      r = g_host ? host_q[i][0] : dsp_q[i][0];
      check("bram_we", i, bram_we[i], r.we);
      check("bram_addr", i, bram_addr[i], r.addr);
      if (r.we) check("bram_din", i, bram_din[i], r.din);
    end else begin
      check("idle_bram_we", i, bram_we[i], 0);
      check("idle_bram_addr", i, bram_addr[i], dsp_addr[i]);
    end
    check("dsp_dout_valid", i, dsp_dout_valid[i], ex && !rd_q[i][0].is_host);
    if (ex && !rd_q[i][0].is_host) check("dsp_dout", i, dsp_dout[i], rd_q[i][0].data);
    check("host_dout_valid", i, host_dout_valid[i], resp_v[i]);
    if (resp_v[i]) check("host_dout", i, host_dout[i], resp_d[i]);

    if (dsp_dout_valid[i]) last_dsp_data[i] = dsp_dout[i];
    if (host_dout_valid[i] && host_dout_ready[i]) last_host_data[i] = host_dout[i];
    if (host_ready[i]) begin
      host_grants[i]++;
      if (first_run[i] < 0) first_run[i] = obs_run[i];
      obs_run[i] = 0;
    end else if (dsp_ready[i] && host_valid[i]) begin
      obs_run[i]++;
    end

    if (resp_v[i] && host_dout_ready[i]) resp_v[i] = 1'b0;
    if (ex) begin
      if (rd_q[i][0].is_host) begin
        resp_v[i] = 1'b1;
        resp_d[i] = rd_q[i][0].data;
      end
      void'(rd_q[i].pop_front());
    end
    if (g_dsp || g_host) begin
      if (r.we) shadow[i][r.addr] = r.din;
      else rd_q[i].push_back('{due: cyc + lat_of(i), is_host: g_host, data: shadow[i][r.addr]});
      if (g_host) void'(host_q[i].pop_front());
      else        void'(dsp_q[i].pop_front());
    end
    if (g_host || !elig)           starve[i] = 0;
    else if (starve[i] < sm_of(i)) starve[i]++;
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) model_cycle(i);
    @(posedge clk);
    cyc++;
    #1 drive();
  endtask

  function automatic bit busy_any();
    bit b = 1'b0;
    for (int i = 0; i < 2; i++)
      if (dsp_q[i].size() > 0 || host_q[i].size() > 0 || rd_q[i].size() > 0 || resp_v[i]) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (n < budget && busy_any()) begin
      tick();
      n++;
    end
    check("drain_within_budget", 0, busy_any(), 0);
    repeat (2) tick();
  endtask

  task automatic push_dsp(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int i = 0; i < 2; i++) dsp_q[i].push_back('{we: we, addr: a, din: d});
  endtask

  task automatic push_host(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int i = 0; i < 2; i++) host_q[i].push_back('{we: we, addr: a, din: d});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      host_dout_ready[i] = 1'b1;
      starve[i]          = 0;
      resp_v[i]          = 1'b0;
      resp_d[i]          = '0;
      obs_run[i]         = 0;
      first_run[i]       = -1;
      host_grants[i]     = 0;
      last_dsp_data[i]   = '0;
      last_host_data[i]  = '0;
    end
    @(posedge clk);
    #1 drive();

    // Reset held, then idle with no valids.
    repeat (3) tick();
    rst = 1'b1;
    drive();
    repeat (3) tick();

    // DSP write then read of the same word.
    push_dsp(1'b1, 10'h005, 32'hDEADBEEF);
    push_dsp(1'b0, 10'h005, 32'h0);
    drive();
    drain(50);
    for (int i = 0; i < 2; i++) check("dsp_rd_after_wr", i, last_dsp_data[i], 32'hDEADBEEF);

    // Continuous DSP traffic with a waiting host read: host must get the slot after STARVE_MAX grants.
    for (int i = 0; i < 2; i++) begin
      first_run[i] = -1;
      obs_run[i]   = 0;
    end
    for (int k = 0; k < 20; k++) push_dsp(1'($urandom), AW'(k), $urandom);
    push_host(1'b0, 10'h010, 32'h0);
    drive();
    drain(100);
    for (int i = 0; i < 2; i++) check("starve_run_len", i, first_run[i], sm_of(i));

    // Held host response under backpressure; the second host read must wait for the handshake.
    for (int i = 0; i < 2; i++) begin
      host_dout_ready[i] = 1'b0;
      host_grants[i]     = 0;
    end
    push_host(1'b0, 10'h003, 32'h0);
    push_host(1'b0, 10'h004, 32'h0);
    for (int k = 0; k < 6; k++) push_dsp(1'($urandom), AW'(k + 2), $urandom);
    drive();
    repeat (14) tick();
    for (int i = 0; i < 2; i++) check("host_grants_while_held", i, host_grants[i], 1);
    for (int i = 0; i < 2; i++) host_dout_ready[i] = 1'b1;
    drain(50);

    // Host write then read at the top address.
    push_host(1'b1, 10'h3FF, 32'h12345678);
    push_host(1'b0, 10'h3FF, 32'h0);
    drive();
    drain(50);
    for (int i = 0; i < 2; i++) check("host_rd_top_addr", i, last_host_data[i], 32'h12345678);

    // Back-to-back DSP read / host read / DSP read to check per-port routing.
    push_dsp(1'b0, 10'h005, 32'h0);
    drive();
    tick();
    push_host(1'b0, 10'h3FF, 32'h0);
    drive();
    tick();
    push_dsp(1'b0, 10'h010, 32'h0);
    drive();
    drain(50);

    // Reset asserted while a DSP read is in flight and a host read is pending.
    push_dsp(1'b0, 10'h005, 32'h0);
    push_host(1'b0, 10'h010, 32'h0);
    drive();
    tick();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    drive();
    drain(50);

    // Randomized mixed traffic with random host backpressure on a small address window.
    for (int n = 0; n < 400; n++) begin
      if (dsp_q[0].size() < 3 && dsp_q[1].size() < 3 && $urandom_range(0, 9) < 6)
        push_dsp(1'($urandom), AW'($urandom_range(0, 15)), $urandom);
      if (host_q[0].size() < 2 && host_q[1].size() < 2 && $urandom_range(0, 9) < 3)
        push_host(1'($urandom), AW'($urandom_range(0, 15)), $urandom);
      for (int i = 0; i < 2; i++) host_dout_ready[i] = ($urandom_range(0, 3) != 0);
      drive();
      tick();
    end
    for (int i = 0; i < 2; i++) host_dout_ready[i] = 1'b1;
    drain(200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
